fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage with a prefetch buffer. It replaces the bare PC-plus-4 fetch logic at the front of the 5-stage core. It drives the instruction-memory address, captures each returned word with its PC into a DEPTH-entry FIFO, and presents entries to decode through a valid/ready handshake. It adds two things the current fetch path lacks: decode back-pressure (stall) and PC redirect with buffer flush, for branches, jumps and traps.

## Interface
- XLEN, 32, address/PC width (≥ 32)
- DEPTH, 4, prefetch buffer entries; power of two, ≥ 2
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- pc_start  in  XLEN  PC loaded while rst is high
- iaddr  out  XLEN  instruction-memory address (= fetch PC)
- ireq  out  1  fetch performed this cycle; instruction is captured only when high
- instruction  in  32  imem read data, valid in the same cycle as iaddr (combinational memory)
- redirect  in  1  flush buffer and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] forced to 0
- d_valid  out  1  head entry valid
- d_ready  in  1  decode accepts head entry
- d_instr  out  32  head instruction
- d_pc  out  XLEN  head PC
- d_pcplus4  out  XLEN  head PC + 4
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- State:
  - fetch PC register pc_f.
  - FIFO storage of {instr, pc}, DEPTH entries.
  - Read pointer and write pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter count.
- Outputs:
  - iaddr = pc_f.
  - ireq = !rst && !redirect && (count != DEPTH).
  - d_valid = (count != 0).
  - d_instr, d_pc and d_pcplus4 read combinationally from the read-pointer entry.
  - d_pcplus4 = d_pc + 4, truncated to XLEN.
- Enqueue occurs when ireq is high:
  - Write {instruction, pc_f} at the write pointer and advance the write pointer.
  - pc_f <= pc_f + 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0x00000000).
- Dequeue occurs when d_valid && d_ready:
  - Advance the read pointer.
- Count update each cycle: count += enqueue − dequeue.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Enqueue is impossible when full, so count never exceeds DEPTH.
  - Dequeue is impossible when empty, so count never goes below 0.
- Redirect has highest priority:
  - No enqueue that cycle.
  - Next cycle: count = 0 and both pointers = 0.
  - pc_f <= {redirect_pc[XLEN-1:2], 2'b00}.
  - d_valid is not masked in the redirect cycle. A handshake that completes in that cycle counts as transferred; discarding it is the consumer's job.
- Reset (asynchronous, any time, including mid-fill or during a redirect):
  - pc_f = pc_start, count = 0, pointers = 0.
  - d_valid = 0, ireq = 0, iaddr = pc_start.
  - While rst is held, pc_f tracks pc_start.
  - FIFO storage is not reset; d_instr, d_pc and d_pcplus4 are don't-care while d_valid = 0.
- No instruction decode or alignment checks beyond forcing bits [1:0] of redirect_pc to 0.

## Timing
- Fetch-to-decode latency: a word fetched in cycle N is visible on d_* in cycle N+1 (registered buffer).
- Steady-state throughput is 1 instruction/cycle with d_ready held high. count settles at 1 and ireq stays high.
- Back-pressure with d_ready low:
  - ireq stays high until count reaches DEPTH, then drops.
  - iaddr holds the next unfetched PC.
  - Exactly DEPTH fetches occur from empty before the stall.
- Full with a dequeue in cycle N: count = DEPTH−1 in N+1 and ireq goes high in N+1. The one-cycle bubble is accepted; there is no bypass.
- Redirect asserted in cycle N:
  - iaddr = redirect_pc in N+1 and ireq is high in N+1.
  - First redirected entry on d_* in N+2.
  - d_valid = 0 in N+1.
- Back-to-back redirects: the last one wins; each flushes.
- First cycle after rst falls: ireq = 1 and iaddr = pc_start. First entry on d_* one cycle later.

## Test plan
- Reset and stream:
  - Stimulus: pc_start = 0x1000, rst released, d_ready = 1, imem returns word = address.
  - Required: d_valid first high one cycle after release with d_pc = 0x1000, d_instr = 0x1000, d_pcplus4 = 0x1004. Then one entry per cycle, PC +4 each.
- Back-pressure fill and drain:
  - Stimulus: d_ready = 0 after reset, DEPTH = 4.
  - Required: exactly 4 ireq pulses, then count = 4, ireq = 0, iaddr = 0x1010.
  - Then raise d_ready. Required: entries 0x1000..0x100C are delivered in order, and fetch resumes at 0x1010 the cycle after the first dequeue.
- Redirect with a partial buffer:
  - Stimulus: with count = 3, pulse redirect with redirect_pc = 0x2003.
  - Required: next cycle count = 0, d_valid = 0, iaddr = 0x2000. d_pc = 0x2000 the cycle after that.
  - No stale PC 0x10xx appears after the flush.
- PC wrap-around:
  - Stimulus: pc_start = 0xFFFFFFF8.
  - Required: d_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. d_pcplus4 for 0xFFFFFFFC equals 0x00000000.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously, between clock edges, with count = 2 and pc_start = 0x4000.
  - Required: d_valid = 0, count = 0, iaddr = 0x4000 immediately, without waiting for a clock edge.
  - After release, delivery restarts at 0x4000.
- Simultaneous events:
  - Stimulus: a dequeue coincident with a redirect.
  - Required: that head transfer completes and the buffer empties.
  - Stimulus: enqueue and dequeue in the same cycle at count = 2.
  - Required: count remains 2.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with a DEPTH-entry prefetch buffer, decode handshake and redirect flush.
// Latency: a word fetched in cycle N is presented on d_* in cycle N+1; redirect in N shows its first entry in N+2.
// Backpressure: d_ready low fills the buffer; ireq drops at DEPTH entries and resumes the cycle after a dequeue.

// fetch_fifo: generic circular buffer with synchronous flush and a combinational head read.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: a push while full and a pop while empty are ignored; flush overrides both.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Qualify requests against occupancy so the counter can never overflow or underflow.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    push_ok = push && !full && !flush;
    pop_ok  = pop && !empty && !flush;
  end

  // Pointers and occupancy; DEPTH is a power of two so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage is data-only and deliberately left out of reset; the head is qualified by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Head entry is read straight from the array so decode sees it with no extra register stage.
  always_comb begin
    head_data = mem[rd_ptr];
  end

endmodule

module fetch_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [XLEN-1:0]            pc_start,
  output logic [XLEN-1:0]            iaddr,
  output logic                       ireq,
  input  logic [31:0]                instruction,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [31:0]                d_instr,
  output logic [XLEN-1:0]            d_pc,
  output logic [XLEN-1:0]            d_pcplus4,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 32 + XLEN;

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] redirect_aligned;
  logic [EW-1:0]   head_entry;
  logic            buf_full;
  logic            buf_empty;
  logic            dequeue;

  // Fetch request and decode-side handshake; redirect suppresses the fetch in its own cycle.
  always_comb begin
    redirect_aligned = redirect_pc & ~XLEN'(3);
    ireq             = !rst && !redirect && !buf_full;
    d_valid          = !buf_empty;
    dequeue          = d_valid && d_ready;
    // While reset is held the address follows pc_start directly, not only at clock edges.
    iaddr            = rst ? pc_start : pc_f;
  end

  // Fetch PC: reload on reset, jump on redirect, otherwise step by one word per fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f <= pc_start;
    end else if (redirect) begin
      pc_f <= redirect_aligned;
    end else if (ireq) begin
      pc_f <= pc_f + XLEN'(4);
    end
  end

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (ireq),
    .push_data ({instruction, pc_f}),
    .pop       (dequeue),
    .head_data (head_entry),
    .count     (count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Split the head entry for decode and derive the fall-through PC.
  always_comb begin
    d_instr   = head_entry[EW-1:XLEN];
    d_pc      = head_entry[XLEN-1:0];
    d_pcplus4 = d_pc + XLEN'(4);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run,
// all outputs compared every cycle against a queue-based reference model.
module tb_fetch_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     pc_start = 32'h1000;
  logic [31:0]     iaddr;
  logic            ireq;
  logic [31:0]     instruction;
  logic            redirect = 1'b0;
  logic [31:0]     redirect_pc = '0;
  logic            d_valid;
  logic            d_ready = 1'b0;
  logic [31:0]     d_instr;
  logic [31:0]     d_pc;
  logic [31:0]     d_pcplus4;
  logic [CW-1:0]   count;
  logic [31:0]     salt = '0;

  // Reference model: next fetch PC plus the ordered list of buffered entries.
  logic [31:0] pc_m;
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ireq_pulses = 0;

  always #5 clk = ~clk;

  // Combinational instruction memory: word is the address, optionally scrambled.
  assign instruction = iaddr ^ salt;

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_start    (pc_start),
    .iaddr       (iaddr),
    .ireq        (ireq),
    .instruction (instruction),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_instr     (d_instr),
    .d_pc        (d_pc),
    .d_pcplus4   (d_pcplus4),
    .count       (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q_pc.delete();
    q_in.delete();
  endtask

  task automatic check_outputs();
    bit          ev;
    bit          ei;
    logic [31:0] ea;
    ev = (q_pc.size() != 0);
    ei = !rst && !redirect && (q_pc.size() < DEPTH);
    ea = rst ? pc_start : pc_m;
    chk("ireq", {63'd0, ireq}, {63'd0, ei});
    chk("iaddr", {32'd0, iaddr}, {32'd0, ea});
    chk("d_valid", {63'd0, d_valid}, {63'd0, ev});
    chk("count", 64'(count), 64'(q_pc.size()));
    if (ev) begin
      chk("d_pc", {32'd0, d_pc}, {32'd0, q_pc[0]});
      chk("d_instr", {32'd0, d_instr}, {32'd0, q_in[0]});
      chk("d_pcplus4", {32'd0, d_pcplus4}, {32'd0, q_pc[0] + 32'd4});
    end
  endtask

  // One clock: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic cycle(input logic r, input logic [31:0] rpc, input logic rdy);
    bit enq;
    bit deq;
    redirect    = r;
    redirect_pc = rpc;
    d_ready     = rdy;
    #1;
    check_outputs();
    enq = !rst && !r && (q_pc.size() < DEPTH);
    deq = (q_pc.size() != 0) && rdy;
    if (ireq) ireq_pulses++;
    @(posedge clk);
    if (rst) begin
      model_clear();
      pc_m = pc_start;
    end else if (r) begin
      model_clear();
      pc_m = rpc & ~32'd3;
    end else begin
      if (deq) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (enq) begin
        q_pc.push_back(pc_m);
        q_in.push_back(pc_m ^ salt);
        pc_m = pc_m + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] pcs);
    rst      = 1'b1;
    pc_start = pcs;
    model_clear();
    pc_m = pcs;
    cycle(1'b0, 32'd0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    pc_m = 32'h1000;
    @(negedge clk);

    // Reset state, then stream with decode always ready.
    cycle(1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    cycle(1'b0, 32'd0, 1'b1);
    chk("first_d_pc", {32'd0, d_pc}, 64'h1000);
    chk("first_d_instr", {32'd0, d_instr}, 64'h1000);
    chk("first_d_pcplus4", {32'd0, d_pcplus4}, 64'h1004);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b1);

    // Fill with decode stalled, then drain.
    do_reset(32'h1000);
    ireq_pulses = 0;
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b0);
    chk("fill_pulses", 64'(ireq_pulses), 64'd4);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ireq", {63'd0, ireq}, 64'd0);
    chk("fill_iaddr", {32'd0, iaddr}, 64'h1010);
    cycle(1'b0, 32'd0, 1'b1);
    chk("resume_ireq", {63'd0, ireq}, 64'd1);
    chk("resume_iaddr", {32'd0, iaddr}, 64'h1010);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b1);

    // Redirect with three entries buffered.
    do_reset(32'h1000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0);
    chk("pre_redir_count", 64'(count), 64'd3);
    cycle(1'b1, 32'h2003, 1'b0);
    chk("redir_count", 64'(count), 64'd0);
    chk("redir_d_valid", {63'd0, d_valid}, 64'd0);
    chk("redir_iaddr", {32'd0, iaddr}, 64'h2000);
    cycle(1'b0, 32'd0, 1'b1);
    chk("redir_d_pc", {32'd0, d_pc}, 64'h2000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1);

    // Dequeue coincident with redirect, then enqueue+dequeue at count 2.
    cycle(1'b1, 32'h3000, 1'b1);
    chk("deq_redir_count", 64'(count), 64'd0);
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    chk("two_count", 64'(count), 64'd2);
    cycle(1'b0, 32'd0, 1'b1);
    chk("enq_deq_count", 64'(count), 64'd2);

    // PC wrap-around.
    do_reset(32'hFFFF_FFF8);
    cycle(1'b0, 32'd0, 1'b1);
    chk("wrap_pc0", {32'd0, d_pc}, 64'hFFFF_FFF8);
    cycle(1'b0, 32'd0, 1'b1);
    chk("wrap_pc1", {32'd0, d_pc}, 64'hFFFF_FFFC);
    chk("wrap_pcplus4", {32'd0, d_pcplus4}, 64'h0);
    cycle(1'b0, 32'd0, 1'b1);
    chk("wrap_pc2", {32'd0, d_pc}, 64'h0);

    // Asynchronous reset between edges with two entries buffered.
    do_reset(32'h1000);
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    chk("pre_arst_count", 64'(count), 64'd2);
    #2;
    pc_start = 32'h4000;
    rst      = 1'b1;
    model_clear();
    pc_m = 32'h4000;
    #1;
    chk("arst_d_valid", {63'd0, d_valid}, 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_iaddr", {32'd0, iaddr}, 64'h4000);
    chk("arst_ireq", {63'd0, ireq}, 64'd0);
    @(negedge clk);
    cycle(1'b0, 32'd0, 1'b1);
    rst = 1'b0;
    cycle(1'b0, 32'd0, 1'b1);
    chk("arst_restart_pc", {32'd0, d_pc}, 64'h4000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1);

    // Randomized traffic: random stalls, redirects and memory contents.
    salt = $urandom;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) salt = $urandom;
      cycle(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
